// File: rtl/lcd_ctrl_param_if.sv
// Bus bundle between the LCD window controller and its
// host, IROM and IRAM.
interface lcd_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    output cmd,
    output cmd_valid,
    output IROM_Q,
    input  IROM_rd,
    input  IROM_A,
    input  IRAM_valid,
    input  IRAM_D,
    input  IRAM_A,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd,
    input  cmd_valid,
    input  IROM_Q,
    output IROM_rd,
    output IROM_A,
    output IRAM_valid,
    output IRAM_D,
    output IRAM_A,
    output busy,
    output done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image-window controller: loads an image from IROM,
// runs 2x2 window commands, streams the image to IRAM.
module lcd_ctrl_param #(
  parameter int DW     = 8,
  parameter int W_LOG2 = 3,
  parameter int H_LOG2 = 3
) (
  input logic          clk,
  input logic          reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int W  = 1 << W_LOG2;
  localparam int H  = 1 << H_LOG2;
  localparam int N  = W * H;
  localparam int AW = W_LOG2 + H_LOG2;

  localparam logic [H_LOG2-1:0] R0   = H_LOG2'(H / 2 - 1);
  localparam logic [W_LOG2-1:0] C0   = W_LOG2'(W / 2 - 1);
  localparam logic [H_LOG2-1:0] RMAX = H_LOG2'(H - 2);
  localparam logic [W_LOG2-1:0] CMAX = W_LOG2'(W - 2);
  localparam logic [AW-1:0]     LAST = AW'(N - 1);

  localparam logic [3:0] C_WR  = 4'd0;
  localparam logic [3:0] C_SU  = 4'd1;
  localparam logic [3:0] C_SD  = 4'd2;
  localparam logic [3:0] C_SL  = 4'd3;
  localparam logic [3:0] C_SR  = 4'd4;
  localparam logic [3:0] C_MAX = 4'd5;
  localparam logic [3:0] C_MIN = 4'd6;
  localparam logic [3:0] C_AVG = 4'd7;
  localparam logic [3:0] C_CCR = 4'd8;
  localparam logic [3:0] C_CR  = 4'd9;
  localparam logic [3:0] C_MRX = 4'd10;
  localparam logic [3:0] C_MRY = 4'd11;
  localparam logic [3:0] C_ORG = 4'd12;
  localparam logic [3:0] C_INV = 4'd13;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;

  logic [DW-1:0]     pix [N];
  logic [H_LOG2-1:0] r, r_nxt;
  logic [W_LOG2-1:0] c, c_nxt;

  logic [AW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] p0, p1, p2, p3;
  logic [DW-1:0] n0, n1, n2, n3;

  logic [DW-1:0] mx01, mx23, mx;
  logic [DW-1:0] mn01, mn23, mn;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  assign a0 = {r, c};
  assign a1 = {r, c + W_LOG2'(1)};
  assign a2 = {r + H_LOG2'(1), c};
  assign a3 = {r + H_LOG2'(1), c + W_LOG2'(1)};

  assign p0 = pix[a0];
  assign p1 = pix[a1];
  assign p2 = pix[a2];
  assign p3 = pix[a3];

  assign mx01 = (p0 > p1) ? p0 : p1;
  assign mx23 = (p2 > p3) ? p2 : p3;
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn01 = (p0 < p1) ? p0 : p1;
  assign mn23 = (p2 < p3) ? p2 : p3;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;

  // Two extra bits so the four-pixel sum never overflows.
  assign sum = {2'b00, p0} + {2'b00, p1}
             + {2'b00, p2} + {2'b00, p3};
  assign avg = sum[DW+1:2];

  // Next window contents and origin for the presented cmd.
  always_comb begin
    n0    = p0;
    n1    = p1;
    n2    = p2;
    n3    = p3;
    r_nxt = r;
    c_nxt = c;
    unique case (bus.cmd)
      C_SU: if (r != '0) r_nxt = r - H_LOG2'(1);
      C_SD: if (r < RMAX) r_nxt = r + H_LOG2'(1);
      C_SL: if (c != '0) c_nxt = c - W_LOG2'(1);
      C_SR: if (c < CMAX) c_nxt = c + W_LOG2'(1);
      C_MAX: begin
        n0 = mx;
        n1 = mx;
        n2 = mx;
        n3 = mx;
      end
      C_MIN: begin
        n0 = mn;
        n1 = mn;
        n2 = mn;
        n3 = mn;
      end
      C_AVG: begin
        n0 = avg;
        n1 = avg;
        n2 = avg;
        n3 = avg;
      end
      C_CCR: begin
        n0 = p1;
        n1 = p3;
        n3 = p2;
        n2 = p0;
      end
      C_CR: begin
        n0 = p2;
        n2 = p3;
        n3 = p1;
        n1 = p0;
      end
      C_MRX: begin
        n0 = p2;
        n2 = p0;
        n1 = p3;
        n3 = p1;
      end
      C_MRY: begin
        n0 = p1;
        n1 = p0;
        n2 = p3;
        n3 = p2;
      end
      C_ORG: begin
        r_nxt = R0;
        c_nxt = C0;
      end
      C_INV: begin
        n0 = ~p0;
        n1 = ~p1;
        n2 = ~p2;
        n3 = ~p3;
      end
      default: ;
    endcase
  end

  // Control FSM, pixel array and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_LOAD;
      r              <= R0;
      c              <= C0;
      for (int i = 0; i < N; i++) pix[i] <= '0;
      bus.IROM_rd    <= 1'b1;
      bus.IROM_A     <= '0;
      bus.IRAM_valid <= 1'b0;
      bus.IRAM_A     <= '0;
      bus.IRAM_D     <= '0;
      bus.busy       <= 1'b1;
      bus.done       <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          pix[bus.IROM_A] <= bus.IROM_Q;
          bus.IROM_A      <= bus.IROM_A + AW'(1);
          if (bus.IROM_A == LAST) begin
            state       <= S_IDLE;
            bus.IROM_rd <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            bus.busy <= 1'b1;
            if (bus.cmd == C_WR) begin
              state          <= S_WRITE;
              bus.IRAM_valid <= 1'b1;
              bus.IRAM_A     <= '0;
              bus.IRAM_D     <= pix[0];
            end else begin
              state   <= S_EXEC;
              r       <= r_nxt;
              c       <= c_nxt;
              pix[a0] <= n0;
              pix[a1] <= n1;
              pix[a2] <= n2;
              pix[a3] <= n3;
            end
          end
        end
        S_EXEC: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        S_WRITE: begin
          if (bus.IRAM_A == LAST) begin
            state          <= S_DONE;
            bus.IRAM_valid <= 1'b0;
            bus.done       <= 1'b1;
          end else begin
            bus.IRAM_A <= bus.IRAM_A + AW'(1);
            bus.IRAM_D <= pix[bus.IRAM_A + AW'(1)];
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: an 8x8/DW=8 instance
// and a 16x4/DW=10 instance, both fed a ramp IROM.
module tb_lcd_ctrl_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       sel = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;

  lcd_ctrl_param_if #(.DW(8),  .AW(6)) ifa ();
  lcd_ctrl_param_if #(.DW(10), .AW(6)) ifb ();

  assign ifa.cmd       = cmd;
  assign ifb.cmd       = cmd;
  assign ifa.cmd_valid = cmd_valid & ~sel;
  assign ifb.cmd_valid = cmd_valid & sel;
  assign ifa.IROM_Q    = 8'(ifa.IROM_A);
  assign ifb.IROM_Q    = 10'(ifb.IROM_A);

  lcd_ctrl_param #(.DW(8), .W_LOG2(3), .H_LOG2(3)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa.slave)
  );

  lcd_ctrl_param #(.DW(10), .W_LOG2(4), .H_LOG2(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb.slave)
  );

  logic       busy_m, done_m, vld_m, romrd_m;
  logic [5:0] ra_m, roma_m;
  logic [9:0] rd_m;

  assign busy_m  = sel ? ifb.busy       : ifa.busy;
  assign done_m  = sel ? ifb.done       : ifa.done;
  assign vld_m   = sel ? ifb.IRAM_valid : ifa.IRAM_valid;
  assign romrd_m = sel ? ifb.IROM_rd    : ifa.IROM_rd;
  assign ra_m    = sel ? ifb.IRAM_A     : ifa.IRAM_A;
  assign roma_m  = sel ? ifb.IROM_A     : ifa.IROM_A;
  assign rd_m    = sel ? ifb.IRAM_D     : {2'b00, ifa.IRAM_D};

  int n_cmp = 0;
  int n_err = 0;
  int m   [64];
  int cap [64];

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic setw(input int a0, input int st,
                      input int v0, input int v1,
                      input int v2, input int v3);
    m[a0]        = v0;
    m[a0 + 1]    = v1;
    m[a0 + st]   = v2;
    m[a0 + st + 1] = v3;
  endtask

  task automatic reload();
    int cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (sel) rst_b = 1'b1;
    else rst_a = 1'b1;
    #1;
    chk("rst_busy",  busy_m,  1);
    chk("rst_romrd", romrd_m, 1);
    chk("rst_vld",   vld_m,   0);
    chk("rst_done",  done_m,  0);
    chk("rst_ra",    ra_m,    0);
    chk("rst_rd",    rd_m,    0);
    chk("rst_roma",  roma_m,  0);
    @(negedge clk);
    if (sel) rst_b = 1'b0;
    else rst_a = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy_m && cnt < 200);
    chk("load_cycles", cnt, 64);
    chk("load_romrd", romrd_m, 0);
    for (int i = 0; i < 64; i++) m[i] = i;
  endtask

  task automatic send(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_busy_hi", busy_m, 1);
    @(negedge clk);
    chk("cmd_busy_lo", busy_m, 0);
  endtask

  task automatic sendn(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) send(c);
  endtask

  task automatic do_write(input string tag);
    int errs;
    errs = 0;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (!vld_m || !busy_m || done_m || ra_m != 6'(k))
        errs++;
      cap[ra_m] = int'(rd_m);
      @(negedge clk);
    end
    chk({tag, "_seq"},   errs,   0);
    chk({tag, "_done1"}, done_m, 1);
    chk({tag, "_vld0"},  vld_m,  0);
    chk({tag, "_busy1"}, busy_m, 1);
    chk({tag, "_hold"},  ra_m,   63);
    @(negedge clk);
    chk({tag, "_done0"}, done_m, 0);
    chk({tag, "_busy0"}, busy_m, 0);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (cap[i] != m[i]) errs++;
    chk({tag, "_img"}, errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] alt [6];
    int cnt;
    int img1 [64];

    reload();
    do_write("ramp");
    chk("ramp_63", cap[63], 63);

    send(4'd7);
    setw(27, 8, 31, 31, 31, 31);
    do_write("avg");
    chk("avg_p0", cap[27], 31);

    reload();
    send(4'd5);
    setw(27, 8, 36, 36, 36, 36);
    do_write("max");
    chk("max_p3", cap[36], 36);

    reload();
    send(4'd6);
    setw(27, 8, 27, 27, 27, 27);
    do_write("min");

    reload();
    send(4'd9);
    setw(27, 8, 35, 27, 36, 28);
    do_write("cr");
    chk("cr_p0", cap[27], 35);

    reload();
    send(4'd8);
    send(4'd10);
    send(4'd11);
    send(4'd14);
    setw(27, 8, 35, 27, 36, 28);
    do_write("rot");

    reload();
    sendn(4'd4, 5);
    sendn(4'd2, 5);
    send(4'd5);
    setw(54, 8, 63, 63, 63, 63);
    send(4'd12);
    send(4'd6);
    setw(27, 8, 27, 27, 27, 27);
    sendn(4'd1, 5);
    sendn(4'd3, 5);
    send(4'd5);
    setw(0, 8, 9, 9, 9, 9);
    do_write("shift");
    chk("sat_54", cap[54], 63);

    reload();
    alt[0] = 4'd4;
    alt[1] = 4'd3;
    alt[2] = 4'd4;
    alt[3] = 4'd3;
    alt[4] = 4'd5;
    alt[5] = 4'd13;
    for (int i = 0; i < 6; i++) begin
      cmd = alt[i];
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    setw(29, 8, 38, 38, 38, 38);
    do_write("alt1");
    for (int i = 0; i < 64; i++) img1[i] = cap[i];
    do_write("alt2");
    cnt = 0;
    for (int i = 0; i < 64; i++)
      if (cap[i] != img1[i]) cnt++;
    chk("alt_repeat", cnt, 0);

    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (ra_m != 6'd20 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_k", ra_m, 20);
    #2;
    rst_a = 1'b1;
    #1;
    chk("abort_vld", vld_m, 0);
    chk("abort_busy", busy_m, 1);
    reload();
    send(4'd13);
    setw(27, 8, 228, 227, 220, 219);
    do_write("inv");
    chk("inv_p0", cap[27], 228);

    @(negedge clk);
    rst_a = 1'b1;
    sel = 1'b1;
    reload();
    do_write("b_ramp");
    send(4'd13);
    setw(23, 16, 1000, 999, 984, 983);
    sendn(4'd4, 10);
    send(4'd5);
    setw(30, 16, 47, 47, 47, 47);
    sendn(4'd2, 3);
    send(4'd6);
    setw(46, 16, 47, 47, 47, 47);
    send(4'd12);
    send(4'd5);
    setw(23, 16, 1000, 1000, 1000, 1000);
    do_write("b_ops");
    chk("b_inv_23", cap[23], 1000);
    chk("b_sat_31", cap[31], 47);
    chk("b_sd_63", cap[63], 47);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
